// File: rtl/phv_merge_pkg.sv
// phv_merge_pkg: shared FSM states, PHV width helper and container slice macro for phv_container_merge.
`ifndef PHV_MERGE_PKG_SV
`define PHV_MERGE_PKG_SV
`define PHV_CONT(i, dw) ((i)*(dw)) +: (dw)
package phv_merge_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;
  function automatic int phv_width(input int meta_w, input int n, input int dw);
    return meta_w + n * dw;
  endfunction
endpackage
`endif

// File: rtl/phv_merge_slot.sv
// phv_merge_slot: one PHV container buffer; first expected ALU result wins, anything else is a duplicate.
module phv_merge_slot #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          mask,
  input  logic [DW-1:0] orig,
  input  logic          capture_en,
  input  logic          alu_valid,
  input  logic [DW-1:0] alu_data,
  output logic [DW-1:0] data,
  output logic          exp_bit,
  output logic          got,
  output logic          cap,
  output logic          dup
);
  assign cap = capture_en & alu_valid & exp_bit & ~got;
  assign dup = alu_valid & ~cap;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data    <= '0;
      exp_bit <= 1'b0;
      got     <= 1'b0;
    end else if (load) begin
      data    <= orig;
      exp_bit <= mask;
      got     <= 1'b0;
    end else if (cap) begin
      data <= alu_data;
      got  <= 1'b1;
    end
  end
endmodule

// File: rtl/phv_container_merge.sv
// phv_container_merge: splices ALU container results into the held PHV and emits it downstream.
// Optional collect watchdog enabled by defining PHV_MERGE_TIMEOUT_EN.
module phv_container_merge import phv_merge_pkg::*; #(
  parameter int NUM_ALU        = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int META_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [phv_width(META_WIDTH, NUM_ALU, DATA_WIDTH)-1:0] phv_in,
  input  logic [NUM_ALU-1:0]                                   phv_in_mask,
  input  logic                                                 phv_in_valid,
  output logic                                                 phv_in_ready,
  input  logic [NUM_ALU*DATA_WIDTH-1:0]                        alu_data_in,
  input  logic [NUM_ALU-1:0]                                   alu_valid_in,
  output logic                                                 alu_ready_out,
  output logic [phv_width(META_WIDTH, NUM_ALU, DATA_WIDTH)-1:0] phv_out,
  output logic                                                 phv_out_valid,
  input  logic                                                 phv_out_ready,
  output logic                                                 err_dup,
  output logic                                                 err_timeout
);
  localparam int CW = NUM_ALU * DATA_WIDTH;
  localparam int W  = phv_width(META_WIDTH, NUM_ALU, DATA_WIDTH);
  logic [1:0] state;
  logic late, load, capture_en, all_in, tmo, done;
  logic [META_WIDTH-1:0] meta;
  logic [CW-1:0] cont;
  logic [NUM_ALU-1:0] exp_v, got, cap, dup;
  assign load          = state == IDLE && phv_in_valid;
  // ALUs answer one cycle after seeing ready, so the first EMIT cycle still captures
  assign capture_en    = state == COLLECT || late;
  assign all_in        = (got | cap) == exp_v;
  assign done          = state == COLLECT && (all_in || tmo);
  assign phv_in_ready  = state == IDLE;
  assign phv_out_valid = state == EMIT;
  assign alu_ready_out = state == COLLECT && |exp_v;
  assign phv_out       = {meta, cont};
  for (genvar i = 0; i < NUM_ALU; i++) begin : g_slot
    phv_merge_slot #(.DW(DATA_WIDTH)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .mask       (phv_in_mask[i]),
      .orig       (phv_in[`PHV_CONT(i, DATA_WIDTH)]),
      .capture_en (capture_en),
      .alu_valid  (alu_valid_in[i]),
      .alu_data   (alu_data_in[`PHV_CONT(i, DATA_WIDTH)]),
      .data       (cont[`PHV_CONT(i, DATA_WIDTH)]),
      .exp_bit    (exp_v[i]),
      .got        (got[i]),
      .cap        (cap[i]),
      .dup        (dup[i])
    );
  end
`ifdef PHV_MERGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;
  assign tmo = state == COLLECT && cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= state == COLLECT ? cnt + 1'b1 : '0;
      if (tmo && !all_in) err_timeout <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      late    <= 1'b0;
      meta    <= '0;
      err_dup <= 1'b0;
    end else begin
      late  <= done;
      state <= load ? COLLECT : done ? EMIT : (state == EMIT && phv_out_ready) ? IDLE : state;
      if (load) meta <= phv_in[W-1:CW];
      if (|dup) err_dup <= 1'b1;
    end
  end
endmodule

// File: tb/tb_phv_container_merge.sv
// tb_phv_container_merge: directed scoreboard bench for phv_container_merge (optionally with PHV_MERGE_TIMEOUT_EN).
module tb_phv_container_merge;
  localparam int N = 8, DW = 32, MW = 256, CW = N * DW, W = MW + CW;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] phv_in = '0, phv_out;
  logic [N-1:0] phv_in_mask = '0, alu_valid_in = '0;
  logic phv_in_valid = 1'b0, phv_in_ready, alu_ready_out, phv_out_valid;
  logic phv_out_ready = 1'b1, err_dup, err_timeout;
  logic [CW-1:0] alu_data_in = '0;
  int checks = 0, failures = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] last_exp, p;
  int n;

  phv_container_merge #(.NUM_ALU(N), .DATA_WIDTH(DW), .META_WIDTH(MW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .phv_in(phv_in), .phv_in_mask(phv_in_mask), .phv_in_valid(phv_in_valid),
    .phv_in_ready(phv_in_ready), .alu_data_in(alu_data_in), .alu_valid_in(alu_valid_in),
    .alu_ready_out(alu_ready_out), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .phv_out_ready(phv_out_ready), .err_dup(err_dup), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_pop(input string tag);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no-expected-entry expected=scoreboard-entry", tag);
    end else begin
      last_exp = sb.pop_front();
      chk(tag, phv_out, last_exp);
    end
  endtask

  function automatic logic [W-1:0] rand_phv();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] put(input logic [W-1:0] v, input int i, input logic [DW-1:0] d);
    v[i*DW +: DW] = d;
    return v;
  endfunction

  task automatic accept(input logic [W-1:0] v, input logic [N-1:0] m, input logic [W-1:0] expv);
    chk("in_ready_before_accept", W'(phv_in_ready), W'(1));
    phv_in = v;
    phv_in_mask = m;
    phv_in_valid = 1'b1;
    sb.push_back(expv);
    tick();
    phv_in_valid = 1'b0;
  endtask

  task automatic alu_pulse(input logic [N-1:0] v, input logic [CW-1:0] d);
    alu_valid_in = v;
    alu_data_in = d;
    tick();
    alu_valid_in = '0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_in_ready", W'(phv_in_ready), W'(1));
    chk("rst_alu_ready", W'(alu_ready_out), W'(0));
    chk("rst_out_valid", W'(phv_out_valid), W'(0));
    chk("rst_phv_out", phv_out, '0);
    chk("rst_err_dup", W'(err_dup), W'(0));
    chk("rst_err_timeout", W'(err_timeout), W'(0));
    rst_n = 1'b1;
    tick();

    // empty mask: straight pass-through two cycles after accept
    p = rand_phv();
    accept(p, 8'h00, p);
    chk("t1_no_alu_ready", W'(alu_ready_out), W'(0));
    chk("t1_not_yet_valid", W'(phv_out_valid), W'(0));
    tick();
    chk("t1_valid_at_T2", W'(phv_out_valid), W'(1));
    chk("t1_no_alu_ready_emit", W'(alu_ready_out), W'(0));
    chk_pop("t1_phv_out");
    tick();
    chk("t1_back_idle", W'(phv_in_ready), W'(1));

    // two containers arriving three cycles apart
    p = rand_phv();
    accept(p, 8'h05, put(put(p, 0, 32'h11), 2, 32'h22));
    chk("t2_alu_ready", W'(alu_ready_out), W'(1));
    chk("t2_in_ready_low", W'(phv_in_ready), W'(0));
    alu_pulse(8'h01, CW'(32'h11));
    tick();
    tick();
    chk("t2_still_collect", W'(phv_out_valid), W'(0));
    alu_pulse(8'h04, put('0, 2, 32'h22) >> 0);
    chk("t2_valid_after_alu2", W'(phv_out_valid), W'(1));
    chk_pop("t2_phv_out");
    tick();

    // all eight in one cycle
    p = rand_phv();
    begin
      logic [W-1:0] e;
      logic [CW-1:0] d;
      e = p;
      for (int i = 0; i < N; i++) begin
        d[i*DW +: DW] = 32'hA0000000 + i;
        e = put(e, i, 32'hA0000000 + i);
      end
      accept(p, 8'hFF, e);
      alu_pulse(8'hFF, d);
    end
    chk("t3_valid", W'(phv_out_valid), W'(1));
    chk_pop("t3_phv_out");
    chk("t3_err_dup_clear", W'(err_dup), W'(0));
    tick();
    chk("t3_single_emit", W'(phv_out_valid), W'(0));
    chk("t3_err_dup_after", W'(err_dup), W'(0));

    // first write wins; repeats and unexpected slots flag err_dup
    phv_out_ready = 1'b0;
    p = rand_phv();
    accept(p, 8'h01, put(p, 0, 32'hA1));
    alu_pulse(8'h01, CW'(32'hA1));
    chk("t4_valid", W'(phv_out_valid), W'(1));
    chk_pop("t4_phv_out");
    alu_pulse(8'h09, put(put('0, 0, 32'hB2), 3, 32'h33) >> 0);
    chk("t4_first_wins", phv_out, last_exp);
    chk("t4_err_dup", W'(err_dup), W'(1));
    phv_out_ready = 1'b1;
    tick();

    // downstream backpressure holds output and blocks new input
    phv_out_ready = 1'b0;
    p = rand_phv();
    accept(p, 8'h00, p);
    tick();
    chk("t5_valid", W'(phv_out_valid), W'(1));
    chk_pop("t5_phv_out");
    phv_in = rand_phv();
    phv_in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_hold", phv_out, last_exp);
      chk("t5_in_ready_low", W'(phv_in_ready), W'(0));
    end
    phv_in_valid = 1'b0;
    phv_out_ready = 1'b1;
    tick();
    chk("t5_released", W'(phv_out_valid), W'(0));
    chk("t5_idle", W'(phv_in_ready), W'(1));

`ifdef PHV_MERGE_TIMEOUT_EN
    p = rand_phv();
    accept(p, 8'h02, p);
    n = 0;
    while (!phv_out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t6_timeout_latency", W'(n), W'(16));
    chk_pop("t6_phv_out");
    chk("t6_err_timeout", W'(err_timeout), W'(1));
    tick();
`else
    chk("t6_err_timeout_tied", W'(err_timeout), W'(0));
`endif

    // reset in the middle of collection
    p = rand_phv();
    accept(p, 8'h10, p);
    sb.delete();
    chk("t7_in_collect", W'(alu_ready_out), W'(1));
    rst_n = 1'b0;
    tick();
    chk("t7_rst_in_ready", W'(phv_in_ready), W'(1));
    chk("t7_rst_alu_ready", W'(alu_ready_out), W'(0));
    chk("t7_rst_out_valid", W'(phv_out_valid), W'(0));
    chk("t7_rst_phv_out", phv_out, '0);
    chk("t7_rst_err_dup", W'(err_dup), W'(0));
    chk("t7_rst_err_timeout", W'(err_timeout), W'(0));
    rst_n = 1'b1;
    tick();
    chk("t7_idle_after", W'(phv_in_ready), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
